// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - memory-mapped I/O port responder
// PortOut register, synchronized PortIn, rising-edge counter and sticky status flags.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          EDGE_BIT    = 0,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] PORTOUT_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut
);

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_EDGE_CNT = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;

  logic [2:0]       offset;
  logic             rd_en;
  logic             wr_en;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       prev;
  logic [1:0]       settle;
  logic             armed;
  logic             rise;
  logic             chg;
  logic [CNT_W-1:0] cnt;
  logic             change_flag;
  logic             ovf_flag;
  logic             wr_cnt;
  logic             status_clr;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   rise_ext;
  logic [CNT_W:0]   cnt_sum;
  logic             unused_addr_lsb;

  assign Hit             = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset          = Address[4:2];
  assign unused_addr_lsb = ^Address[1:0];
  assign rd_en           = Hit & MemRead;
  assign wr_en           = Hit & MemWrite;

  // Events are suppressed until the synchronizer pipeline has refilled after reset.
  assign armed = (settle == 2'd3);
  assign rise  = armed & sync2[EDGE_BIT] & ~prev[EDGE_BIT];
  assign chg   = armed & (sync2 != prev);

  assign wr_cnt     = wr_en && (offset == OFF_EDGE_CNT);
  assign status_clr = rd_en && (offset == OFF_STATUS);

  // A load of the counter still absorbs a same-cycle edge; the carry out flags a wrap.
  assign cnt_base = wr_cnt ? WriteData[CNT_W-1:0] : cnt;
  assign rise_ext = {{CNT_W{1'b0}}, rise};
  assign cnt_sum  = {1'b0, cnt_base} + rise_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut <= PORTOUT_RST;
    end else if (wr_en && (offset == OFF_PORT_OUT)) begin
      PortOut <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      prev  <= 8'h00;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle <= 2'd0;
    end else if (!armed) begin
      settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (wr_cnt || rise) begin
      cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  // A set event in the same cycle as a clearing STATUS read keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_flag <= 1'b0;
      ovf_flag    <= 1'b0;
    end else begin
      change_flag <= chg | (change_flag & ~status_clr);
      ovf_flag    <= cnt_sum[CNT_W] | (ovf_flag & ~status_clr);
    end
  end

  always_comb begin
    ReadData = 32'h0000_0000;
    if (rd_en) begin
      case (offset)
        OFF_PORT_OUT: ReadData = PortOut;
        OFF_PORT_IN:  ReadData = {24'h00_0000, sync2};
        OFF_EDGE_CNT: ReadData = 32'(cnt);
        OFF_STATUS:   ReadData = {29'h0, armed, ovf_flag, change_flag};
        default:      ReadData = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus (Address/WriteData/MemWrite/MemRead/ReadData).
- It answers loads and stores that fall inside a small I/O window, next to the data RAM.
- It drives the 32-bit PortOut and samples the 8-bit PortIn through a synchronizer.
- It counts rising edges on one PortIn bit and keeps sticky status flags.
- Top level selects its ReadData over the RAM when Hit is high.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base of the 32-byte I/O window; bits [4:0] must be 0.
- EDGE_BIT, 0, index of the PortIn bit whose rising edges are counted (0..7).
- CNT_W, 16, edge counter width (1..32).
- PORTOUT_RST, 32'h0000_0000, reset value of PortOut.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store strobe from control unit.
- MemRead  input  1  load strobe from control unit.
- Address  input  32  byte address (ALU result).
- WriteData  input  32  store data (register file ReadData2).
- PortIn  input  8  asynchronous external inputs.
- ReadData  output  32  load data, combinational.
- Hit  output  1  Address is inside the window (combinational).
- PortOut  output  32  registered output port.

Behaviour:
- Decode:
  - Hit = (Address[31:5] == BASE_ADDR[31:5]).
  - Offset = Address[4:2]; Address[1:0] are ignored.
  - Hit does not depend on MemRead/MemWrite.
- Register map (word offsets):
  - 0 PORT_OUT, RW: PortOut value.
  - 1 PORT_IN, RO: {24'b0, sync2}.
  - 2 EDGE_CNT, RW: zero-extended counter; a write loads WriteData[CNT_W-1:0].
  - 3 STATUS: bit0 CHANGE (sticky), bit1 OVF (sticky), bit2 ARMED; bits 31:3 are 0.
  - 4..7 reserved: read 0, writes ignored.
- ReadData:
  - Combinational: register value when Hit & MemRead, else 32'h0.
  - Always returns the pre-clock-edge value. Same-cycle read+write to one register returns the old value.
- Writes commit on the rising clk edge when Hit & MemWrite.
  - Writes to PORT_IN or STATUS are ignored.
- Synchronizer: sync1 <= PortIn, sync2 <= sync1, prev <= sync2, every clock.
- Settle counter (2 bits): counts 0→3 after reset release, then holds. ARMED = (settle == 3).
  - Edge and change detection are ignored while not ARMED. No spurious counts on reset release with PortIn high.
- Event detection (combinational, gated by ARMED):
  - rise = sync2[EDGE_BIT] & ~prev[EDGE_BIT].
  - chg = (sync2 != prev).
- Latency:
  - A PortIn change is readable in PORT_IN after 2 clk edges.
  - The resulting count/CHANGE update lands on the 3rd edge.
- Counter update per edge, in priority order:
  - Write to EDGE_CNT: cnt <= WriteData + rise (same-cycle edge not lost).
  - Else rise: cnt <= cnt + 1, wrapping from all-ones to 0 and setting OVF.
  - A write with WriteData = all-ones plus rise also wraps to 0 and sets OVF.
- STATUS flags:
  - CHANGE is set by chg. OVF is set on wrap.
  - A read of STATUS (Hit & MemRead, offset 3) clears CHANGE and OVF at that clock edge.
  - If a set event occurs in the same cycle as the clearing read, the flag remains 1 (set wins).
- Reset (async, reset==0):
  - PortOut = PORTOUT_RST.
  - sync1, sync2, prev, cnt, CHANGE, OVF and settle are all 0; ARMED = 0.
  - ReadData and Hit are combinational and follow their inputs.
  - Reset asserted mid-operation clears state immediately, with no clock needed.
  - The settle sequence restarts on release.
- X/garbage on Address while both strobes are low must not change any state.

Test Plan:
- Reset and arm:
  - Hold reset=0 with PortIn=8'hFF, release, run 5 clocks, then read offset 2 and offset 3.
  - Required: PortOut=0, EDGE_CNT=0, STATUS=32'h4 (ARMED only, no spurious edge/change).
- PORT_OUT and decode:
  - Store 32'hDEAD_BEEF to BASE+0.
  - Required: PortOut=32'hDEAD_BEEF after that edge; a load from BASE+0 returns the same value with Hit=1.
  - Load from BASE+32: required Hit=0, ReadData=0. Store to BASE+4: required no effect.
- Synchronizer latency:
  - Armed, change PortIn 8'h00→8'h01 mid-cycle.
  - Required: PORT_IN reads 1 after the 2nd edge; EDGE_CNT=1 and STATUS[0]=1 after the 3rd edge.
  - A following STATUS read returns 32'h5; the next STATUS read returns 32'h4.
- Wrap and overflow (CNT_W=4):
  - Store 4'hF to EDGE_CNT, then apply one rising edge on PortIn[0].
  - Required: EDGE_CNT=0, STATUS bit1=1.
- Simultaneous events:
  - Store 5 to EDGE_CNT on the same edge a rise is detected. Required: EDGE_CNT=6.
  - Read STATUS in the same cycle chg is detected. Required: read returns the old value, and CHANGE remains 1 afterward.
- Async reset mid-operation:
  - Drive reset low between clock edges with PortOut=32'h1234 and cnt=3.
  - Required: PortOut=0 and cnt=0 immediately, with no clock edge.
  - After release: ARMED=0 for 3 clocks, then 1.
